sat_sweeper: RTL and testbench
==============================

Name: sat_sweeper

Overview:
Exhaustive candidate sweeper for an external combinational predicate block. It steps a BITS-wide candidate vector through every value from 0 to 2^BITS-1. Each value is held for a programmable number of cycles set by a prescaler. The block samples the predicate result for each value, records hit statistics and signals completion. It sits between the board-level top and the predicate logic, and drives the status LEDs.

Parameters:
BITS, 3, candidate vector width; 1..16.
DELAY, 22, prescaler width; each candidate is held 2^DELAY cycles; 0..31; DELAY=0 gives one cycle per candidate with no prescaler logic.
CNT_W, 16, hit counter width; 1..32.
STOP_ON_FIRST, 0, 1 = finish on the first hit.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle start request
candidate  output  BITS  value presented to the predicate
result  input  1  predicate output for the current candidate (combinational from candidate)
busy  output  1  high while sweeping
done  output  1  sweep finished; held until the next start or reset
found  output  1  at least one hit this sweep
first_hit  output  BITS  lowest candidate with result=1
hit_count  output  CNT_W  number of hits, saturating

Behaviour:
- Reset values: state IDLE, candidate=0, prescaler=0, busy=0, done=0, found=0, first_hit=0, hit_count=0.
- Reset is asynchronous, mid-sweep included. It returns all state to reset values at once. No partial results survive.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: runs the sweep as described below.
  - DONE: done=1; start=1 -> RUN.
- Start accept (IDLE or DONE), at edge E0:
  - candidate<=0, prescaler<=0.
  - found/first_hit/hit_count cleared.
  - done<=0, busy<=1.
- start while in RUN is ignored.
- Prescaler and sampling:
  - In RUN the prescaler increments every cycle.
  - tick = prescaler at all-ones. DELAY=0 means tick every cycle.
  - result is sampled only on tick, so each candidate is stable for exactly 2^DELAY cycles before sampling.
- On a tick with result=1:
  - hit_count increments, saturating at 2^CNT_W-1.
  - If found=0: found<=1 and first_hit<=candidate. first_hit is never overwritten within a sweep.
- On a tick, completion:
  - If candidate is all-ones, or STOP_ON_FIRST=1 and result=1: go to DONE, busy<=0, done<=1. candidate holds its last value.
  - Otherwise candidate<=candidate+1. No wrap within a sweep.
- Latency: a full sweep ends with done rising at edge E0 + 2^(BITS+DELAY).
- Simultaneous events: a tick on the same edge as a terminal hit updates statistics and enters DONE on that same edge.
- Outputs are registered, except that candidate is directly the counter register.

Optional Feature:
SAT_SWEEPER_LAST_HIT_EN
- Defined: adds output last_hit [BITS-1:0], reset 0 and cleared on start. It is updated to candidate on every sampled hit, so after a sweep it holds the highest hit.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package sat_sweeper_pkg:
  - state typedef enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Localparam helpers for the terminal prescaler value.
  - Saturating-increment function.
- Sub-module sweep_prescaler(clk, rst, clear, en, tick), parametrised by DELAY. A generate branch handles DELAY=0 as tick=en.

Test Plan:
- BITS=3, DELAY=2, result = AND of all candidate bits; pulse start -> done rises 32 cycles after start; found=1, first_hit=7, hit_count=1, candidate=7.
- Same config, result=0 constant -> done at 32 cycles; found=0, first_hit=0, hit_count=0.
- BITS=3, DELAY=0, CNT_W=2, result=1 constant -> done after 8 cycles; first_hit=0; hit_count saturates at 3.
- BITS=3, DELAY=2, STOP_ON_FIRST=1, result=(candidate==5) -> done 24 cycles after start; candidate holds 5; first_hit=5; hit_count=1.
- Assert rst mid-sweep at candidate=4 -> all outputs 0 and IDLE immediately, without waiting for clk; start pulses during RUN cause no restart (done timing unchanged); start in DONE clears statistics and resweeps.
- With SAT_SWEEPER_LAST_HIT_EN, BITS=3, DELAY=1, result=candidate[0] -> first_hit=1, last_hit=7, hit_count=4.

Source files
------------

// File: rtl/sat_sweeper_pkg.sv
// Shared state encoding and arithmetic helpers for the candidate sweeper.
package sat_sweeper_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // Terminal prescaler count for a given DELAY: all-ones in the low DELAY bits.
    function automatic logic [31:0] presc_last(input int unsigned delay);
        return 32'((64'd1 << delay) - 64'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sat_sweeper_if.sv
// Sweeper <-> predicate/status bundle; master is the sweeper side.
interface sat_sweeper_if #(
    parameter int BITS  = 3,
    parameter int CNT_W = 16
);
    logic             start;
    logic [BITS-1:0]  candidate;
    logic             result;
    logic             busy;
    logic             done;
    logic             found;
    logic [BITS-1:0]  first_hit;
    logic [CNT_W-1:0] hit_count;
`ifdef SAT_SWEEPER_LAST_HIT_EN
    logic [BITS-1:0]  last_hit;

    modport master (input start, result,
                    output candidate, busy, done, found, first_hit, hit_count, last_hit);
    modport slave  (output start, result,
                    input candidate, busy, done, found, first_hit, hit_count, last_hit);
`else
    modport master (input start, result,
                    output candidate, busy, done, found, first_hit, hit_count);
    modport slave  (output start, result,
                    input candidate, busy, done, found, first_hit, hit_count);
`endif
endinterface

// File: rtl/sat_sweeper_prescaler.sv
// Hold-time prescaler: tick when the DELAY-bit counter is all-ones while enabled.
// DELAY=0 degenerates to tick=en with no state.
module sweep_prescaler
    import sat_sweeper_pkg::*;
#(
    parameter int DELAY = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);
    generate
        if (DELAY == 0) begin : g_none
            logic unused_presc;
            assign unused_presc = ^{clk, rst, clear};
            assign tick = en;
        end else begin : g_cnt
            logic [DELAY-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (en) begin
                    cnt_d = cnt_q + DELAY'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign tick = en && (cnt_q == DELAY'(presc_last(DELAY)));
        end
    endgenerate
endmodule

// File: rtl/sat_sweeper.sv
// Exhaustive sweeper: candidate 0..2^BITS-1, each held 2^DELAY cycles, done 2^(BITS+DELAY) after start.
// SAT_SWEEPER_LAST_HIT_EN adds last_hit (highest sampled hit this sweep).
module sat_sweeper
    import sat_sweeper_pkg::*;
#(
    parameter int BITS          = 3,
    parameter int DELAY         = 22,
    parameter int CNT_W         = 16,
    parameter int STOP_ON_FIRST = 0
) (
    input  logic clk,
    input  logic rst,
    sat_sweeper_if.master bus
);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [1:0]       state_q, state_d;
    logic [BITS-1:0]  cand_q, cand_d;
    logic [BITS-1:0]  first_q, first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
`ifdef SAT_SWEEPER_LAST_HIT_EN
    logic [BITS-1:0]  last_q, last_d;
`endif

    logic accept;
    logic running;
    logic tick;
    logic terminal;

    assign running  = (state_q == ST_RUN);
    // Start is honoured from IDLE and DONE alike; a start during RUN is dropped.
    assign accept   = !running && bus.start;
    assign terminal = (&cand_q) || ((STOP_ON_FIRST != 0) && bus.result);

    sweep_prescaler #(.DELAY(DELAY)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (running),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        first_d = first_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        found_d = found_q;
`ifdef SAT_SWEEPER_LAST_HIT_EN
        last_d  = last_q;
`endif
        if (accept) begin
            state_d = ST_RUN;
            cand_d  = '0;
            first_d = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            found_d = 1'b0;
`ifdef SAT_SWEEPER_LAST_HIT_EN
            last_d  = '0;
`endif
        end else if (running && tick) begin
            if (bus.result) begin
                cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
                if (!found_q) begin
                    found_d = 1'b1;
                    first_d = cand_q;
                end
`ifdef SAT_SWEEPER_LAST_HIT_EN
                last_d = cand_q;
`endif
            end
            if (terminal) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                cand_d = cand_q + BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            first_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
`ifdef SAT_SWEEPER_LAST_HIT_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
`ifdef SAT_SWEEPER_LAST_HIT_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.candidate = cand_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.found     = found_q;
    assign bus.first_hit = first_q;
    assign bus.hit_count = cnt_q;
`ifdef SAT_SWEEPER_LAST_HIT_EN
    assign bus.last_hit  = last_q;
`endif
endmodule

// File: tb/tb_sat_sweeper.sv
// Bench for sat_sweeper: four BITS=3 instances (DELAY/CNT_W/STOP_ON_FIRST variants), predicate = mask lookup.
module tb_sat_sweeper;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  start_v = '0;
    logic [7:0]  mask_v [4];
    logic [3:0]  busy_v, done_v, found_v;
    logic [2:0]  cand_v  [4];
    logic [2:0]  first_v [4];
    logic [15:0] cnt_v   [4];
`ifdef SAT_SWEEPER_LAST_HIT_EN
    logic [2:0]  last_v  [4];
`endif

    int checks   = 0;
    int failures = 0;

    // Instance configs: 0:{D2,C16,S0} 1:{D0,C2,S0} 2:{D2,C16,S1} 3:{D1,C16,S0}
    function automatic int dly_of(int i);
        return (i == 1) ? 0 : (i == 3) ? 1 : 2;
    endfunction
    function automatic int cw_of(int i);
        return (i == 1) ? 2 : 16;
    endfunction
    function automatic int stop_of(int i);
        return (i == 2) ? 1 : 0;
    endfunction

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam int D  = (g == 1) ? 0 : (g == 3) ? 1 : 2;
            localparam int CW = (g == 1) ? 2 : 16;
            localparam int SF = (g == 2) ? 1 : 0;

            sat_sweeper_if #(.BITS(3), .CNT_W(CW)) bus_i ();

            sat_sweeper #(.BITS(3), .DELAY(D), .CNT_W(CW), .STOP_ON_FIRST(SF)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (bus_i)
            );

            assign bus_i.start  = start_v[g];
            assign bus_i.result = mask_v[g][bus_i.candidate];
            assign busy_v[g]    = bus_i.busy;
            assign done_v[g]    = bus_i.done;
            assign found_v[g]   = bus_i.found;
            assign cand_v[g]    = bus_i.candidate;
            assign first_v[g]   = bus_i.first_hit;
            assign cnt_v[g]     = 16'(bus_i.hit_count);
`ifdef SAT_SWEEPER_LAST_HIT_EN
            assign last_v[g]    = bus_i.last_hit;
`endif
        end
    endgenerate

    typedef struct {
        int         idx;
        logic [7:0] mask;
        int         lat;
        int         found;
        int         first;
        int         cnt;
        int         cand;
        int         last;
    } vec_t;

    // Reference: walk candidates in order, collect hits, stop early only when configured.
    function automatic vec_t model(int idx, logic [7:0] mask);
        vec_t v;
        int   cmax = (1 << cw_of(idx)) - 1;
        v.idx = idx; v.mask = mask;
        v.found = 0; v.first = 0; v.cnt = 0; v.last = 0; v.cand = 7;
        for (int c = 0; c < 8; c++) begin
            if (mask[c]) begin
                if (v.found == 0) begin
                    v.found = 1;
                    v.first = c;
                end
                v.last = c;
                if (v.cnt < cmax) v.cnt++;
                if (stop_of(idx) != 0) begin
                    v.cand = c;
                    break;
                end
            end
        end
        v.lat = (v.cand + 1) << dly_of(idx);
        return v;
    endfunction

    task automatic check(string tag, string what, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=%0d expected=%0d", tag, what, act, exp);
        end
    endtask

    // Pulse start, then count edges after the accepting edge until done (bounded).
    task automatic run_sweep(int idx, logic [7:0] mask, bit poke, output int lat);
        mask_v[idx] = mask;
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        check("start", "busy", busy_v[idx], 1);
        check("start", "done", done_v[idx], 0);
        check("start", "found", found_v[idx], 0);
        check("start", "hits", cnt_v[idx], 0);
        lat = 0;
        while (!done_v[idx] && lat < 2000) begin
            start_v[idx] = poke && (lat == 10 || lat == 20);
            @(negedge clk);
            lat++;
        end
        start_v[idx] = 1'b0;
    endtask

    task automatic apply(vec_t v, bit poke, string tag);
        int lat;
        run_sweep(v.idx, v.mask, poke, lat);
        check(tag, "latency", lat, v.lat);
        check(tag, "busy", busy_v[v.idx], 0);
        check(tag, "found", found_v[v.idx], v.found);
        check(tag, "first_hit", first_v[v.idx], v.first);
        check(tag, "hit_count", cnt_v[v.idx], v.cnt);
        check(tag, "candidate", cand_v[v.idx], v.cand);
`ifdef SAT_SWEEPER_LAST_HIT_EN
        check(tag, "last_hit", last_v[v.idx], v.last);
`endif
    endtask

    vec_t table_v [6];

    initial begin
        foreach (mask_v[i]) mask_v[i] = '0;
        table_v[0] = '{0, 8'h80, 32, 1, 7, 1, 7, 7};
        table_v[1] = '{0, 8'h00, 32, 0, 0, 0, 7, 0};
        table_v[2] = '{1, 8'hFF,  8, 1, 0, 3, 7, 7};
        table_v[3] = '{2, 8'h20, 24, 1, 5, 1, 5, 5};
        table_v[4] = '{3, 8'hAA, 16, 1, 1, 4, 7, 7};
        table_v[5] = '{2, 8'h00, 32, 0, 0, 0, 7, 0};

        #1;
        for (int i = 0; i < 4; i++) begin
            check("reset", "busy", busy_v[i], 0);
            check("reset", "done", done_v[i], 0);
            check("reset", "candidate", cand_v[i], 0);
            check("reset", "hit_count", cnt_v[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) apply(table_v[i], 1'b0, $sformatf("vec%0d", i));

        // Start pulses during RUN must not restart the sweep.
        apply(table_v[0], 1'b1, "run_start");
        repeat (5) @(negedge clk);
        check("done_hold", "done", done_v[0], 1);
        check("done_hold", "candidate", cand_v[0], 7);
        apply(table_v[1], 1'b0, "resweep");

        // Asynchronous reset mid-sweep, between clock edges.
        mask_v[0] = 8'h06;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        begin
            int n = 0;
            while (cand_v[0] != 3'd4 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("mid_rst", "reached_4", cand_v[0], 4);
        end
        #2 rst = 1'b1;
        #1;
        check("mid_rst", "busy", busy_v[0], 0);
        check("mid_rst", "found", found_v[0], 0);
        check("mid_rst", "first_hit", first_v[0], 0);
        check("mid_rst", "hit_count", cnt_v[0], 0);
        check("mid_rst", "candidate", cand_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("idle", "busy", busy_v[0], 0);
        check("idle", "done", done_v[0], 0);
        check("idle", "candidate", cand_v[0], 0);

        for (int i = 0; i < 16; i++) begin
            int         idx  = int'($urandom_range(0, 3));
            logic [7:0] mask = 8'($urandom);
            apply(model(idx, mask), 1'b0, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
